morse_keyer: RTL and testbench
==============================

// Module: morse_keyer
// PURPOSE
//  Consumes the touchpad press indication (z-threshold) from the touchpad controller and turns it
//  into Morse characters. Presses are debounced, timed in 1 ms ticks and classified as dot or dash.
//  Symbols accumulate until a letter gap; the completed letter is decoded to ASCII.
//  The ASCII character goes out on a valid/ready port to the message buffer. A word gap emits a space.
// PARAMETERS
//  TICK_DIV       27000  cclk cycles per 1 ms tick (27 MHz)
//  DEBOUNCE_MS    20     ms press_in must be stable before press_db follows it
//  DOT_MAX_MS     250    press shorter than this = dot, otherwise dash
//  LETTER_GAP_MS  600    release time that closes a letter
//  WORD_GAP_MS    1400   release time that emits a space (must exceed LETTER_GAP_MS)
// PORTS
//  cclk        in   1  system clock
//  rstb        in   1  synchronous reset, active-low
//  press_in    in   1  raw touch indication (zThreshold), cclk domain, noisy
//  char_ready  in   1  consumer accepts char_ascii when char_valid && char_ready
//  char_valid  out  1  char_ascii holds an unaccepted character
//  char_ascii  out  8  ASCII code: A-Z, 0-9, 8'h20 space, 8'h3F '?'
//  press_db    out  1  debounced press, for LED/speaker feedback
//  sym_count   out  3  symbols captured in current letter (0..5)
//  overflow    out  1  sticky: a character was dropped because char_valid was still high
// BEHAVIOUR
//  Reset values (rstb=0 at posedge cclk): all outputs 0; state IDLE; all counters and buffers 0.
//    Reset mid-operation discards any partial letter and any pending character.
//  Tick: free-running divider 0..TICK_DIV-1 gives a 1-cycle tick. All ms counters advance only on tick.
//    ms counters are 16 bits and saturate at 16'hFFFF.
//  Debounce: press_db takes the value of press_in once press_in != press_db for DEBOUNCE_MS
//    consecutive ticks. The stability counter clears whenever press_in == press_db.
//  FSM, driven by press_db edges:
//    IDLE   rise -> PRESS, dur<=0. Falls are ignored.
//    PRESS  count dur. On fall: append symbol (dur<DOT_MAX_MS ? 0 : 1); gap<=0; go to GAP.
//    GAP    count gap. At the tick where gap reaches LETTER_GAP_MS and sym_count>0: emit letter,
//           then clear sym_count, sym_bits and sym_err.
//           At gap==WORD_GAP_MS: emit 8'h20 if at least one letter has been emitted since the
//           last space; then go to IDLE.
//           On rise: go to PRESS, dur<=0; the current letter continues if it is not yet closed.
//  Symbol buffer: sym_bits[4:0] shifts left and the new symbol enters the LSB (dash=1).
//    On a 6th symbol, sym_err is set and bits/count stay unchanged.
//  Decode (morse_lut): (sym_count, sym_bits) -> ASCII, covering A-Z and 0-9.
//    An unknown pattern or sym_err decodes to 8'h3F. Example: 2,'b01 -> 8'h41 'A'.
//  Output handshake: emitting when char_valid=0 sets char_valid=1 and loads char_ascii on the
//    next cycle. The cycle of char_valid&&char_ready clears char_valid.
//    Emit in the same cycle as an accept: the new character is loaded and char_valid stays 1.
//    Emit while char_valid=1 and no accept: the character is dropped and overflow<=1 (sticky until reset).
//  Latency: char_valid rises 1 cclk after the tick on which the gap count reaches its threshold.
//    char_ascii is stable while char_valid=1.
//  Simultaneous events: a rise of press_db on the letter-gap tick is handled as emit first,
//    then PRESS with the new letter empty.
// STRUCTURE
//  morse_defs.vh: FSM state encodings (IDLE/PRESS/GAP), ASCII_SPACE=8'h20, ASCII_UNKNOWN=8'h3F.
//  Sub-module morse_lut (combinational decode table). Divider, debounce, FSM and output register
//    stay in this module.
// TESTING (sim with TICK_DIV=4; durations in ms ticks)
//  press 100, release 100, press 400, release 700, char_ready=1
//    -> one char_valid pulse with 8'h41, 600 ticks after the last release; then 8'h20 at 1400.
//  glitch: press_in high 10 ticks, low 30 -> press_db never rises, no output.
//  six 100-tick dots separated by 100-tick gaps -> sym_count stays 5, emits 8'h3F.
//  char_ready=0; send "E" then "T" -> char_ascii=8'h45 held, overflow=1, 'T' dropped;
//    raising char_ready accepts 'E'.
//  press 300 (dash), release 800, press 100, release -> 'T' (8'h54) then 'E' (8'h45), no space between.
//  rstb=0 for 1 cycle during PRESS -> all outputs 0; the next full letter decodes normally.

Source files
------------

// File: rtl/morse_keyer_pkg.sv
// Shared types and constants for the touchpad Morse keyer.
// States, ASCII codes and a saturating ms-counter helper.
package morse_keyer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP
  } state_e;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/morse_keyer_if.sv
// Character valid/ready port from the keyer to the message buffer.
// master = keyer side, slave = consumer side.
interface morse_keyer_if;
  import morse_keyer_pkg::*;

  logic       char_valid;
  logic       char_ready;
  logic [7:0] char_ascii;

  modport master (
    output char_valid,
    output char_ascii,
    input  char_ready
  );

  modport slave (
    input  char_valid,
    input  char_ascii,
    output char_ready
  );

endinterface

// File: rtl/morse_keyer_lut.sv
// Morse decode table: symbol count + pattern (dash=1, last symbol
// in LSB) to ASCII; unknown patterns or overlong letters give '?'.
module morse_lut
  import morse_keyer_pkg::*;
(
  input  logic [2:0] sym_count,
  input  logic [4:0] sym_bits,
  input  logic       sym_err,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_UNKNOWN;
    case ({sym_count, sym_bits})
      {3'd1, 5'b00000}: ascii = 8'h45;
      {3'd1, 5'b00001}: ascii = 8'h54;
      {3'd2, 5'b00000}: ascii = 8'h49;
      {3'd2, 5'b00001}: ascii = 8'h41;
      {3'd2, 5'b00010}: ascii = 8'h4E;
      {3'd2, 5'b00011}: ascii = 8'h4D;
      {3'd3, 5'b00000}: ascii = 8'h53;
      {3'd3, 5'b00001}: ascii = 8'h55;
      {3'd3, 5'b00010}: ascii = 8'h52;
      {3'd3, 5'b00011}: ascii = 8'h57;
      {3'd3, 5'b00100}: ascii = 8'h44;
      {3'd3, 5'b00101}: ascii = 8'h4B;
      {3'd3, 5'b00110}: ascii = 8'h47;
      {3'd3, 5'b00111}: ascii = 8'h4F;
      {3'd4, 5'b00000}: ascii = 8'h48;
      {3'd4, 5'b00001}: ascii = 8'h56;
      {3'd4, 5'b00010}: ascii = 8'h46;
      {3'd4, 5'b00100}: ascii = 8'h4C;
      {3'd4, 5'b00110}: ascii = 8'h50;
      {3'd4, 5'b00111}: ascii = 8'h4A;
      {3'd4, 5'b01000}: ascii = 8'h42;
      {3'd4, 5'b01001}: ascii = 8'h58;
      {3'd4, 5'b01010}: ascii = 8'h43;
      {3'd4, 5'b01011}: ascii = 8'h59;
      {3'd4, 5'b01100}: ascii = 8'h5A;
      {3'd4, 5'b01101}: ascii = 8'h51;
      {3'd5, 5'b11111}: ascii = 8'h30;
      {3'd5, 5'b01111}: ascii = 8'h31;
      {3'd5, 5'b00111}: ascii = 8'h32;
      {3'd5, 5'b00011}: ascii = 8'h33;
      {3'd5, 5'b00001}: ascii = 8'h34;
      {3'd5, 5'b00000}: ascii = 8'h35;
      {3'd5, 5'b10000}: ascii = 8'h36;
      {3'd5, 5'b11000}: ascii = 8'h37;
      {3'd5, 5'b11100}: ascii = 8'h38;
      {3'd5, 5'b11110}: ascii = 8'h39;
      default:          ascii = ASCII_UNKNOWN;
    endcase
    if (sym_err) ascii = ASCII_UNKNOWN;
  end

endmodule

// File: rtl/morse_keyer.sv
// Touchpad Morse keyer: debounce, dot/dash timing, letter/word gaps,
// decoded ASCII out on a valid/ready port with sticky overflow.
module morse_keyer
  import morse_keyer_pkg::*;
#(
  parameter int TICK_DIV      = 27000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int DOT_MAX_MS    = 250,
  parameter int LETTER_GAP_MS = 600,
  parameter int WORD_GAP_MS   = 1400
) (
  input  logic          cclk,
  input  logic          rstb,
  input  logic          press_in,
  morse_keyer_if.master chr,
  output logic          press_db,
  output logic [2:0]    sym_count,
  output logic          overflow
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [15:0]   dbc_q, dbc_d;
  logic          db_q, db_d, dbp_q;
  state_e        state_q, state_d;
  logic [15:0]   ms_q, ms_d, ms_inc;
  logic [2:0]    cnt_q, cnt_d;
  logic [4:0]    bits_q, bits_d;
  logic          err_q, err_d;
  logic          word_q, word_d;
  logic          vld_q, vld_d;
  logic [7:0]    asc_q, asc_d;
  logic          ovf_q, ovf_d;
  logic          tick, rise, fall;
  logic          emit, accept;
  logic [7:0]    emit_chr, lut_chr;

  morse_lut u_lut (
    .sym_count (cnt_q),
    .sym_bits  (bits_q),
    .sym_err   (err_q),
    .ascii     (lut_chr)
  );

  always_comb begin
    tick  = (div_q == DW'(TICK_DIV - 1));
    div_d = tick ? '0 : div_q + 1'b1;
    db_d  = db_q;
    dbc_d = dbc_q;
    if (press_in == db_q) begin
      dbc_d = '0;
    end else if (tick) begin
      dbc_d = sat_inc(dbc_q);
      if (dbc_d >= 16'(DEBOUNCE_MS)) begin
        db_d  = press_in;
        dbc_d = '0;
      end
    end
    rise = db_q & ~dbp_q;
    fall = ~db_q & dbp_q;
  end

  always_comb begin
    state_d  = state_q;
    ms_d     = ms_q;
    ms_inc   = sat_inc(ms_q);
    cnt_d    = cnt_q;
    bits_d   = bits_q;
    err_d    = err_q;
    word_d   = word_q;
    emit     = 1'b0;
    emit_chr = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_PRESS;
          ms_d    = '0;
        end
      end
      ST_PRESS: begin
        if (tick) ms_d = ms_inc;
        if (fall) begin
          if (cnt_q == 3'd5) begin
            err_d = 1'b1;
          end else begin
            bits_d = {bits_q[3:0], ms_q >= 16'(DOT_MAX_MS)};
            cnt_d  = cnt_q + 3'd1;
          end
          ms_d    = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          ms_d = ms_inc;
          if (ms_inc == 16'(LETTER_GAP_MS) && cnt_q != '0) begin
            emit     = 1'b1;
            emit_chr = lut_chr;
            cnt_d    = '0;
            bits_d   = '0;
            err_d    = 1'b0;
            word_d   = 1'b1;
          end
          if (ms_inc == 16'(WORD_GAP_MS)) begin
            if (word_q) begin
              emit     = 1'b1;
              emit_chr = ASCII_SPACE;
              word_d   = 1'b0;
            end
            state_d = ST_IDLE;
          end
        end
        // a rise on the closing tick lands after the emit above
        if (rise) begin
          state_d = ST_PRESS;
          ms_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vld_d  = vld_q;
    asc_d  = asc_q;
    ovf_d  = ovf_q;
    accept = vld_q & chr.char_ready;
    if (accept) vld_d = 1'b0;
    if (emit) begin
      if (!vld_q || accept) begin
        vld_d = 1'b1;
        asc_d = emit_chr;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      div_q   <= '0;
      dbc_q   <= '0;
      db_q    <= 1'b0;
      dbp_q   <= 1'b0;
      state_q <= ST_IDLE;
      ms_q    <= '0;
      cnt_q   <= '0;
      bits_q  <= '0;
      err_q   <= 1'b0;
      word_q  <= 1'b0;
      vld_q   <= 1'b0;
      asc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      dbc_q   <= dbc_d;
      db_q    <= db_d;
      dbp_q   <= db_q;
      state_q <= state_d;
      ms_q    <= ms_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      err_q   <= err_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
      asc_q   <= asc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign chr.char_valid = vld_q;
  assign chr.char_ascii = asc_q;
  assign press_db       = db_q;
  assign sym_count      = cnt_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer at TICK_DIV=4: expected characters are queued
// as presses are driven and popped when the keyer hands one over.
module tb_morse_keyer;
  import morse_keyer_pkg::*;

  localparam int TD = 4;

  logic       cclk = 1'b0;
  logic       rstb = 1'b0;
  logic       press_in = 1'b0;
  logic       press_db;
  logic [2:0] sym_count;
  logic       overflow;
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic       glitch_win = 1'b0;
  logic       seen_db = 1'b0;

  morse_keyer_if ifc ();

  morse_keyer #(.TICK_DIV(TD)) dut (
    .cclk      (cclk),
    .rstb      (rstb),
    .press_in  (press_in),
    .chr       (ifc.master),
    .press_db  (press_db),
    .sym_count (sym_count),
    .overflow  (overflow)
  );

  always #5 cclk = ~cclk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  always @(negedge cclk) begin
    if (glitch_win && press_db) seen_db <= 1'b1;
    if (rstb && ifc.char_valid && ifc.char_ready) begin
      if (exp_q.size() == 0) chk("unexp", 16'(ifc.char_valid), 16'h0);
      else chk("char", 16'(ifc.char_ascii), 16'(exp_q.pop_front()));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge cclk);
    #1;
  endtask

  task automatic ticks(input int n);
    cyc(n * TD);
  endtask

  task automatic key(input int on_t, input int off_t);
    press_in = 1'b1;
    ticks(on_t);
    press_in = 1'b0;
    ticks(off_t);
  endtask

  task automatic drain(input string tag, input int max_t);
    for (int i = 0; i < max_t * TD && exp_q.size() > 0; i++) cyc(1);
    chk(tag, 16'(exp_q.size()), 16'h0);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_v"}, 16'(ifc.char_valid), 16'h0);
    chk({tag, "_a"}, 16'(ifc.char_ascii), 16'h0);
    chk({tag, "_db"}, 16'(press_db), 16'h0);
    chk({tag, "_sc"}, 16'(sym_count), 16'h0);
    chk({tag, "_ov"}, 16'(overflow), 16'h0);
  endtask

  initial begin
    ifc.char_ready = 1'b1;
    cyc(3);
    chk_rst("rst0");
    rstb = 1'b1;
    cyc(2);

    // "A" then a space, with latency window around the letter gap
    exp_q.push_back(8'h41);
    key(100, 100);
    key(400, 0);
    ticks(610);
    chk("a_early", 16'(exp_q.size()), 16'h1);
    ticks(20);
    chk("a_lat", 16'(exp_q.size()), 16'h0);
    exp_q.push_back(ASCII_SPACE);
    drain("a_sp", 900);
    chk("a_ov", 16'(overflow), 16'h0);

    // short glitch never debounces
    glitch_win = 1'b1;
    key(10, 30);
    glitch_win = 1'b0;
    cyc(2);
    chk("gl_db", 16'(seen_db), 16'h0);
    chk("gl_sc", 16'(sym_count), 16'h0);

    // six dots: buffer holds at five, letter decodes to '?'
    key(100, 100);
    key(100, 100);
    key(100, 100);
    chk("six_sc3", 16'(sym_count), 16'h3);
    key(100, 100);
    key(100, 100);
    key(100, 100);
    chk("six_sc5", 16'(sym_count), 16'h5);
    exp_q.push_back(ASCII_UNKNOWN);
    exp_q.push_back(ASCII_SPACE);
    drain("six", 1500);

    // consumer stalled: E held, T and space dropped
    ifc.char_ready = 1'b0;
    key(100, 800);
    key(300, 700);
    chk("ov_v", 16'(ifc.char_valid), 16'h1);
    chk("ov_a", 16'(ifc.char_ascii), 16'h45);
    chk("ov_f", 16'(overflow), 16'h1);
    chk("ov_sc", 16'(sym_count), 16'h0);
    ticks(800);
    chk("ov_hold", 16'(ifc.char_ascii), 16'h45);
    exp_q.push_back(8'h45);
    ifc.char_ready = 1'b1;
    drain("ov_acc", 10);
    cyc(2);
    chk("ov_clr", 16'(ifc.char_valid), 16'h0);

    // dash, long gap, dot: T then E then one space
    exp_q.push_back(8'h54);
    exp_q.push_back(8'h45);
    exp_q.push_back(ASCII_SPACE);
    key(300, 800);
    key(100, 0);
    drain("te", 1600);
    chk("te_ov", 16'(overflow), 16'h1);

    // reset in the middle of a press
    press_in = 1'b1;
    ticks(60);
    chk("mid_db", 16'(press_db), 16'h1);
    rstb = 1'b0;
    cyc(1);
    rstb = 1'b1;
    press_in = 1'b0;
    chk_rst("rst1");
    ticks(40);
    exp_q.push_back(8'h4E);
    exp_q.push_back(ASCII_SPACE);
    key(300, 100);
    key(100, 0);
    drain("n", 1600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
